// File: rtl/conv_1x1_sched_03_if.sv
// ----------------------------------------------------------------------------
// conv_1x1_sched_03_if
//   Bundles the control and memory-read signals of the 1x1 convolution
//   sequencer so the sequencer and its consumers connect through one port.
//
//   master : the sequencer (takes start/hold, drives everything else)
//   slave  : the stage / memories side (the mirror image)
//
//   Signals
//     start         begin one layer pass (sampled only while idle)
//     hold          backpressure; freezes the sequence and read strobes
//     stride2       only with CONV1X1_SCHED_STRIDE2_EN: read even rows/cols
//     busy, done    pass in progress / last read of the pass issued
//     wt_rd_en/addr weight memory read
//     fm_rd_en/addr feature-map memory read
//     valid_weight  weight read data valid at the stage
//     valid_pxl     pixel read data valid at the stage
//     acc_first     pixel belongs to input channel 0
//     acc_last      pixel belongs to the last input channel
//     ch_out_idx    output channel of the pixel on valid_pxl
//
//   Optional feature macro: CONV1X1_SCHED_STRIDE2_EN
// ----------------------------------------------------------------------------
interface conv_1x1_sched_03_if #(
  parameter int FM_ADDR_WIDTH = 16,
  parameter int WT_ADDR_WIDTH = 17,
  parameter int CH_OUT_WIDTH  = 9
);
  logic                     start;
  logic                     hold;
`ifdef CONV1X1_SCHED_STRIDE2_EN
  logic                     stride2;
`endif
  logic                     busy;
  logic                     done;
  logic                     wt_rd_en;
  logic [WT_ADDR_WIDTH-1:0] wt_rd_addr;
  logic                     fm_rd_en;
  logic [FM_ADDR_WIDTH-1:0] fm_rd_addr;
  logic                     valid_weight;
  logic                     valid_pxl;
  logic                     acc_first;
  logic                     acc_last;
  logic [CH_OUT_WIDTH-1:0]  ch_out_idx;

`ifdef CONV1X1_SCHED_STRIDE2_EN
  modport master (
    input  start, hold, stride2,
    output busy, done, wt_rd_en, wt_rd_addr, fm_rd_en, fm_rd_addr,
           valid_weight, valid_pxl, acc_first, acc_last, ch_out_idx
  );
  modport slave (
    output start, hold, stride2,
    input  busy, done, wt_rd_en, wt_rd_addr, fm_rd_en, fm_rd_addr,
           valid_weight, valid_pxl, acc_first, acc_last, ch_out_idx
  );
`else
  modport master (
    input  start, hold,
    output busy, done, wt_rd_en, wt_rd_addr, fm_rd_en, fm_rd_addr,
           valid_weight, valid_pxl, acc_first, acc_last, ch_out_idx
  );
  modport slave (
    output start, hold,
    input  busy, done, wt_rd_en, wt_rd_addr, fm_rd_en, fm_rd_addr,
           valid_weight, valid_pxl, acc_first, acc_last, ch_out_idx
  );
`endif
endinterface

// File: rtl/conv_1x1_sched_03.sv
// ----------------------------------------------------------------------------
// conv_1x1_sched_03
//   Read sequencer for the 1x1 convolution stage. For every output channel co
//   and input channel ci it issues one weight read (addr co*CIN+ci) followed by
//   a raster of feature-map reads of channel ci (addr ci*W*H+pix). The read
//   strobes are delayed by the memory latency to form the stage valids, and
//   first/last/co tags ride along with each pixel for the channel adder.
//
//   Ports
//     clk    in  rising-edge clock
//     reset  in  synchronous, active-high
//     bus    conv_1x1_sched_03_if.master (start, hold, [stride2] in;
//            busy, done, read strobes/addresses, valids and tags out)
//
//   Optional feature macro: CONV1X1_SCHED_STRIDE2_EN
//     When defined, stride2 (sampled with start) restricts each channel raster
//     to even rows and columns. When undefined, the full raster is always read.
// ----------------------------------------------------------------------------
module conv_1x1_sched_03 #(
  parameter int IMAGE_WIDTH     = 16,
  parameter int IMAGE_HEIGHT    = 16,
  parameter int CHANNEL_NUM_IN  = 256,
  parameter int CHANNEL_NUM_OUT = 512,
  parameter int MEM_LAT         = 1,
  parameter int FM_ADDR_WIDTH   = 16,
  parameter int WT_ADDR_WIDTH   = 17,
  parameter int CH_OUT_WIDTH    = 9
) (
  input logic                 clk,
  input logic                 reset,
  conv_1x1_sched_03_if.master bus
);

  localparam int COL_W = $clog2(IMAGE_WIDTH + 2);
  localparam int ROW_W = $clog2(IMAGE_HEIGHT + 2);
  localparam int CI_W  = (CHANNEL_NUM_IN  > 1) ? $clog2(CHANNEL_NUM_IN)  : 1;
  localparam int CO_W  = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;

  localparam logic [31:0] W_U    = 32'(IMAGE_WIDTH);
  localparam logic [31:0] H_U    = 32'(IMAGE_HEIGHT);
  localparam logic [31:0] CIN_U  = 32'(CHANNEL_NUM_IN);
  localparam logic [31:0] COUT_U = 32'(CHANNEL_NUM_OUT);
  localparam logic [31:0] NPIX_U = 32'(IMAGE_WIDTH * IMAGE_HEIGHT);

  typedef enum logic [1:0] {
    IDLE,
    WREQ,
    STREAM
  } state_t;

  typedef struct packed {
    logic                    wt;
    logic                    fm;
    logic                    first;
    logic                    last;
    logic [CH_OUT_WIDTH-1:0] ch;
  } tag_t;

  state_t           state;
  logic [CO_W-1:0]  co;
  logic [CI_W-1:0]  ci;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [1:0]       step;
  logic             last_col;
  logic             last_row;
  logic             last_pix;
  logic             last_ci;
  logic             last_co;
  logic             wt_strobe;
  logic             fm_strobe;
  logic [31:0]      wt_addr_full;
  logic [31:0]      fm_addr_full;
  tag_t             stage_in;
  tag_t             pipe [MEM_LAT];

  // The raster is walked as (row, col) rather than a flat pixel index so that
  // the strided mode can skip odd rows/columns with the same counters; with a
  // step of 1 row*W+col is exactly the flat pixel index.
`ifdef CONV1X1_SCHED_STRIDE2_EN
  logic stride_q;
  assign step = stride_q ? 2'd2 : 2'd1;
`else
  assign step = 2'd1;
`endif

  assign last_col = (32'(col) + 32'(step)) >= W_U;
  assign last_row = (32'(row) + 32'(step)) >= H_U;
  assign last_pix = last_col && last_row;
  assign last_ci  = 32'(ci) == (CIN_U - 32'd1);
  assign last_co  = 32'(co) == (COUT_U - 32'd1);

  // Strobes come from the registered state but are gated by the live hold so
  // that a stalled cycle never issues a read.
  assign wt_strobe = (state == WREQ)   && !bus.hold;
  assign fm_strobe = (state == STREAM) && !bus.hold;

  assign wt_addr_full = 32'(co) * CIN_U + 32'(ci);
  assign fm_addr_full = 32'(ci) * NPIX_U + 32'(row) * W_U + 32'(col);

  assign bus.busy       = (state != IDLE);
  assign bus.done       = fm_strobe && last_pix && last_ci && last_co;
  assign bus.wt_rd_en   = wt_strobe;
  assign bus.wt_rd_addr = WT_ADDR_WIDTH'(wt_addr_full);
  assign bus.fm_rd_en   = fm_strobe;
  assign bus.fm_rd_addr = FM_ADDR_WIDTH'(fm_addr_full);

  // Sequencer: one weight request per (co,ci), then the channel raster.
  // Counters only move on unstalled cycles and wrap back to 0 at the end of
  // the pass so that idle addresses sit at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      co    <= '0;
      ci    <= '0;
      col   <= '0;
      row   <= '0;
`ifdef CONV1X1_SCHED_STRIDE2_EN
      stride_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= WREQ;
            co    <= '0;
            ci    <= '0;
            col   <= '0;
            row   <= '0;
`ifdef CONV1X1_SCHED_STRIDE2_EN
            stride_q <= bus.stride2;
`endif
          end
        end
        WREQ: begin
          if (!bus.hold) begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (!bus.hold) begin
            if (last_pix) begin
              col <= '0;
              row <= '0;
              if (!last_ci) begin
                ci    <= ci + CI_W'(1);
                state <= WREQ;
              end else if (!last_co) begin
                ci    <= '0;
                co    <= co + CO_W'(1);
                state <= WREQ;
              end else begin
                ci    <= '0;
                co    <= '0;
                state <= IDLE;
              end
            end else if (last_col) begin
              col <= '0;
              row <= row + ROW_W'(step);
            end else begin
              col <= col + COL_W'(step);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Tags are captured at issue time and zeroed when no pixel read is issued,
  // so they can only be non-zero alongside valid_pxl at the far end.
  always_comb begin
    stage_in    = '0;
    stage_in.wt = wt_strobe;
    if (fm_strobe) begin
      stage_in.fm    = 1'b1;
      stage_in.first = (ci == '0);
      stage_in.last  = last_ci;
      stage_in.ch    = CH_OUT_WIDTH'(co);
    end
  end

  // Fixed-length delay line matching the memory latency. It keeps shifting
  // during hold so reads already issued always reach the stage; reset flushes
  // it, dropping any in-flight tags of an abandoned pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= stage_in;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign bus.valid_weight = pipe[MEM_LAT-1].wt;
  assign bus.valid_pxl    = pipe[MEM_LAT-1].fm;
  assign bus.acc_first    = pipe[MEM_LAT-1].first;
  assign bus.acc_last     = pipe[MEM_LAT-1].last;
  assign bus.ch_out_idx   = pipe[MEM_LAT-1].ch;

endmodule
